// File: rtl/pipe_pkg.sv
// Shared pipeline constants, control-bit indices and slot state for the 5-stage MIPS datapath.
// Imported by the inter-stage latches and their helpers.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam int WB_W = 2;
  localparam int M_W  = 3;

  // WB control group bit positions
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // M control group bit positions
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
  } ctl_t;

  function automatic logic branch_taken(input logic valid, input logic [M_W-1:0] m,
                                        input logic zero);
    return valid & m[BRANCH] & zero;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Destination-vs-source register compare for EX-stage operand forwarding; purely combinational.
// A producer only matches when it is a real instruction that writes a register other than $0.
module fwd_match #(
  parameter int AW = 5
) (
  input  logic          valid,
  input  logic          regwrite,
  input  logic [AW-1:0] wreg,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          match_a,
  output logic          match_b
);

  logic live;

  // $0 is hardwired to zero, so a write to it must never be forwarded
  assign live    = valid & regwrite & (wreg != '0);
  assign match_a = live & (wreg == rs);
  assign match_b = live & (wreg == rt);

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: one-cycle latency, stall holds every field, flush loads a bubble (flush wins).
// Also registers branch-taken and the EX/MEM forwarding-match flags for the next EX cycle.
module ex_mem_latch #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [1:0]        ex_wb_ctl,
  input  logic [2:0]        ex_m_ctl,
  input  logic [DATA_W-1:0] ex_branch_tgt,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              mem_valid,
  output logic [1:0]        mem_wb_ctl,
  output logic [2:0]        mem_m_ctl,
  output logic [DATA_W-1:0] mem_branch_tgt,
  output logic              mem_zero,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [DATA_W-1:0] mem_rd2,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              mem_pcsrc,
  output logic              fwd_a,
  output logic              fwd_b
);

  import pipe_pkg::*;

  slot_t slot_q, slot_d;

  ctl_t              ctl_q, ctl_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic              pcsrc_q, pcsrc_d;
  logic              fwd_a_q, fwd_a_d;
  logic              fwd_b_q, fwd_b_d;

  logic match_a, match_b;
  logic load;

  fwd_match #(
    .AW(REG_AW)
  ) u_fwd_match (
    .valid   (ex_valid),
    .regwrite(ex_wb_ctl[REGWRITE]),
    .wreg    (ex_wreg),
    .rs      (id_rs),
    .rt      (id_rt),
    .match_a (match_a),
    .match_b (match_b)
  );

  assign load = ~flush & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = EMPTY;
    end else if (load) begin
      slot_d = ex_valid ? FULL : EMPTY;
    end
  end

  always_comb begin
    ctl_d     = ctl_q;
    tgt_d     = tgt_q;
    zero_d    = zero_q;
    alu_res_d = alu_res_q;
    rd2_d     = rd2_q;
    wreg_d    = wreg_q;
    pcsrc_d   = pcsrc_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (flush) begin
      ctl_d     = '0;
      tgt_d     = '0;
      zero_d    = 1'b0;
      alu_res_d = '0;
      rd2_d     = '0;
      wreg_d    = '0;
      pcsrc_d   = 1'b0;
      fwd_a_d   = 1'b0;
      fwd_b_d   = 1'b0;
    end else if (load) begin
      // A bubble still carries its data fields; only the control is squashed
      ctl_d.wb  = ex_valid ? ex_wb_ctl : '0;
      ctl_d.m   = ex_valid ? ex_m_ctl  : '0;
      tgt_d     = ex_branch_tgt;
      zero_d    = ex_zero;
      alu_res_d = ex_alu_res;
      rd2_d     = ex_rd2;
      wreg_d    = ex_wreg;
      pcsrc_d   = branch_taken(ex_valid, ex_m_ctl, ex_zero);
      fwd_a_d   = match_a;
      fwd_b_d   = match_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= '0;
      tgt_q     <= '0;
      zero_q    <= 1'b0;
      alu_res_q <= '0;
      rd2_q     <= '0;
      wreg_q    <= '0;
      pcsrc_q   <= 1'b0;
      fwd_a_q   <= 1'b0;
      fwd_b_q   <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      tgt_q     <= tgt_d;
      zero_q    <= zero_d;
      alu_res_q <= alu_res_d;
      rd2_q     <= rd2_d;
      wreg_q    <= wreg_d;
      pcsrc_q   <= pcsrc_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  assign mem_valid      = (slot_q == FULL);
  assign mem_wb_ctl     = ctl_q.wb;
  assign mem_m_ctl      = ctl_q.m;
  assign mem_branch_tgt = tgt_q;
  assign mem_zero       = zero_q;
  assign mem_alu_res    = alu_res_q;
  assign mem_rd2        = rd2_q;
  assign mem_wreg       = wreg_q;
  assign mem_pcsrc      = pcsrc_q;
  assign fwd_a          = fwd_a_q;
  assign fwd_b          = fwd_b_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Bench for ex_mem_latch: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, ex_valid, ex_zero;
  logic [1:0]  ex_wb_ctl;
  logic [2:0]  ex_m_ctl;
  logic [31:0] ex_branch_tgt, ex_alu_res, ex_rd2;
  logic [4:0]  ex_wreg, id_rs, id_rt;

  logic        mem_valid, mem_zero, mem_pcsrc, fwd_a, fwd_b;
  logic [1:0]  mem_wb_ctl;
  logic [2:0]  mem_m_ctl;
  logic [31:0] mem_branch_tgt, mem_alu_res, mem_rd2;
  logic [4:0]  mem_wreg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wreg;
    logic        pcsrc;
    logic        fa;
    logic        fb;
  } view_t;

  view_t exp_v;
  view_t obs;
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_wb_ctl     (ex_wb_ctl),
    .ex_m_ctl      (ex_m_ctl),
    .ex_branch_tgt (ex_branch_tgt),
    .ex_zero       (ex_zero),
    .ex_alu_res    (ex_alu_res),
    .ex_rd2        (ex_rd2),
    .ex_wreg       (ex_wreg),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .mem_valid     (mem_valid),
    .mem_wb_ctl    (mem_wb_ctl),
    .mem_m_ctl     (mem_m_ctl),
    .mem_branch_tgt(mem_branch_tgt),
    .mem_zero      (mem_zero),
    .mem_alu_res   (mem_alu_res),
    .mem_rd2       (mem_rd2),
    .mem_wreg      (mem_wreg),
    .mem_pcsrc     (mem_pcsrc),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign obs = {mem_valid, mem_wb_ctl, mem_m_ctl, mem_branch_tgt, mem_zero, mem_alu_res,
                mem_rd2, mem_wreg, mem_pcsrc, fwd_a, fwd_b};

  // What the stage should hold after the next edge, from the current model and inputs
  function automatic view_t predict(input view_t cur);
    view_t n;
    if (flush) return '0;
    if (stall) return cur;
    n.valid = ex_valid;
    n.wb    = ex_valid ? ex_wb_ctl : 2'b00;
    n.m     = ex_valid ? ex_m_ctl : 3'b000;
    n.tgt   = ex_branch_tgt;
    n.zero  = ex_zero;
    n.alu   = ex_alu_res;
    n.rd2   = ex_rd2;
    n.wreg  = ex_wreg;
    n.pcsrc = ex_valid && ex_m_ctl[2] && ex_zero;
    n.fa    = ex_valid && ex_wb_ctl[1] && (ex_wreg != 0) && (ex_wreg == id_rs);
    n.fb    = ex_valid && ex_wb_ctl[1] && (ex_wreg != 0) && (ex_wreg == id_rt);
    return n;
  endfunction

  task automatic tick();
    exp_v = predict(exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ex_valid = 0; ex_zero = 0;
    ex_wb_ctl = 0; ex_m_ctl = 0; ex_branch_tgt = 0; ex_alu_res = 0; ex_rd2 = 0;
    ex_wreg = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic rand_payload();
    ex_valid      = $urandom_range(0, 3) != 0;
    ex_zero       = $urandom_range(0, 1) == 1;
    ex_wb_ctl     = 2'($urandom);
    ex_m_ctl      = 3'($urandom);
    ex_branch_tgt = $urandom;
    ex_alu_res    = $urandom;
    ex_rd2        = $urandom;
    ex_wreg       = 5'($urandom_range(0, 7));
    id_rs         = 5'($urandom_range(0, 7));
    id_rt         = 5'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    exp_v = '0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 111'b0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    #4 rst_n = 1;
  endtask

  task automatic test_load();
    idle_inputs();
    ex_valid = 1; ex_wb_ctl = 2'b10; ex_m_ctl = 3'b000;
    ex_alu_res = 32'h0000_00AA; ex_wreg = 5'b01010;
    ex_branch_tgt = 32'h0040_0010; ex_rd2 = 32'h1234_5678;
    tick();
    checks++;
    if (mem_wreg !== 5'b01010) begin
      failures++; $display("FAIL load_wreg got=%b want=01010", mem_wreg);
    end
    checks++;
    if (mem_alu_res !== 32'h0000_00AA) begin
      failures++; $display("FAIL load_alu got=%h want=000000aa", mem_alu_res);
    end
    checks++;
    if (mem_valid !== 1'b1) begin
      failures++; $display("FAIL load_valid got=%b want=1", mem_valid);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL load_all got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_stall();
    stall = 1; ex_wreg = 5'b10101; ex_alu_res = 32'hDEAD_BEEF; ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_wreg !== 5'b01010) begin
        failures++; $display("FAIL stall_wreg cyc=%0d got=%b want=01010", i, mem_wreg);
      end
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL stall_all cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    stall = 0;
  endtask

  task automatic test_flush();
    ex_valid = 1; ex_wb_ctl = 2'b11; ex_m_ctl = 3'b100; ex_zero = 1;
    ex_wreg = 5'b00011; id_rs = 5'b00011;
    tick();
    stall = 1; flush = 1;
    tick();
    checks++;
    if ({mem_valid, mem_wb_ctl, mem_m_ctl, mem_pcsrc} !== 7'b0) begin
      failures++;
      $display("FAIL flush_ctl got v=%b wb=%b m=%b pc=%b want all 0",
               mem_valid, mem_wb_ctl, mem_m_ctl, mem_pcsrc);
    end
    checks++;
    if (obs !== 111'b0) begin
      failures++; $display("FAIL flush_all got=%h want=0", obs);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_branch();
    idle_inputs();
    ex_valid = 1; ex_m_ctl = 3'b100; ex_zero = 1; ex_branch_tgt = 32'h0000_0100;
    tick();
    checks++;
    if (mem_pcsrc !== 1'b1) begin
      failures++; $display("FAIL branch_taken got=%b want=1", mem_pcsrc);
    end
    ex_zero = 0;
    tick();
    checks++;
    if (mem_pcsrc !== 1'b0) begin
      failures++; $display("FAIL branch_not_taken got=%b want=0", mem_pcsrc);
    end
    ex_zero = 1; ex_valid = 0;
    tick();
    checks++;
    if (mem_pcsrc !== 1'b0 || obs !== exp_v) begin
      failures++; $display("FAIL branch_bubble got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    ex_valid = 1; ex_wb_ctl = 2'b10; ex_wreg = 5'b11111; id_rs = 5'b11111; id_rt = 5'b00101;
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 2'b10) begin
      failures++; $display("FAIL fwd_r31 got a=%b b=%b want a=1 b=0", fwd_a, fwd_b);
    end
    ex_wreg = 5'b00000; id_rs = 5'b00000;
    tick();
    checks++;
    if (fwd_a !== 1'b0) begin
      failures++; $display("FAIL fwd_r0 got=%b want=0", fwd_a);
    end
    ex_wreg = 5'b00101; id_rs = 5'b00101; id_rt = 5'b00101; ex_wb_ctl = 2'b01;
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 2'b00) begin
      failures++; $display("FAIL fwd_noregwrite got a=%b b=%b want 0 0", fwd_a, fwd_b);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    ex_valid = 1; ex_wb_ctl = 2'b11; ex_m_ctl = 3'b110; ex_zero = 1;
    ex_alu_res = 32'hCAFE_F00D; ex_wreg = 5'b00111; id_rs = 5'b00111;
    tick();
    checks++;
    if (mem_valid !== 1'b1 || obs !== exp_v) begin
      failures++; $display("FAIL arst_preload got=%h want=%h", obs, exp_v);
    end
    #2 rst_n = 0;
    #1;
    exp_v = '0;
    checks++;
    if (obs !== 111'b0) begin
      failures++; $display("FAIL arst_immediate got=%h want=0", obs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 111'b0) begin
      failures++; $display("FAIL arst_held got=%h want=0", obs);
    end
    #4 rst_n = 1;
    tick();
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL arst_reload got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      ex_valid = 1; ex_wb_ctl = 2'b10; ex_wreg = 5'(i + 1); id_rs = 5'(i + 1); id_rt = 5'(i);
      tick();
      checks++;
      if (obs !== exp_v || mem_wreg !== 5'(i + 1)) begin
        failures++; $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_branch();
    test_forwarding();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
EX/MEM pipeline register for the 5-stage MIPS datapath.
- Directly consumes the 5-bit destination-register number produced by the rt/rd select mux (bottom_mux), plus the EX-stage ALU result, store data, branch target, zero flag and the WB/M control groups.
- Holds these for one stage with stall (hold) and flush (bubble) support.
- Provides registered EX/MEM forwarding-match flags to the EX-stage operand muxes.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_AW, 5, register-number width; must match the destination-select mux output width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all stored fields for this cycle
flush  in  1  load a bubble (valid=0, all control cleared)
ex_valid  in  1  EX stage holds a real instruction
ex_wb_ctl  in  2  {regwrite, memtoreg}
ex_m_ctl  in  3  {branch, memread, memwrite}
ex_branch_tgt  in  DATA_W  computed branch target
ex_zero  in  1  ALU zero flag
ex_alu_res  in  DATA_W  ALU result
ex_rd2  in  DATA_W  store data (forwarded rt value)
ex_wreg  in  REG_AW  destination register from the rt/rd select mux
id_rs  in  REG_AW  rs of the instruction entering EX next cycle
id_rt  in  REG_AW  rt of the instruction entering EX next cycle
mem_valid  out  1  stored instruction is real
mem_wb_ctl  out  2  registered WB control
mem_m_ctl  out  3  registered M control
mem_branch_tgt  out  DATA_W  registered branch target
mem_zero  out  1  registered zero flag
mem_alu_res  out  DATA_W  registered ALU result
mem_rd2  out  DATA_W  registered store data
mem_wreg  out  REG_AW  registered destination register
mem_pcsrc  out  1  registered branch-taken: branch & zero & valid
fwd_a  out  1  forward EX/MEM result to ALU operand A next cycle
fwd_b  out  1  forward EX/MEM result to ALU operand B next cycle

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, also mid-operation): all outputs 0. Mid-operation reset discards any in-flight instruction with no partial state kept.
- Latency: one cycle. Inputs sampled at a rising clk edge appear on the outputs after that edge.
- Priority per edge, highest first: reset, flush, stall, normal load.
- Flush:
  - mem_valid, mem_wb_ctl, mem_m_ctl, mem_pcsrc, fwd_a and fwd_b load 0.
  - Data fields (tgt, zero, alu_res, rd2, wreg) load 0.
  - Flush overrides a simultaneous stall.
- Stall (flush=0): every register holds its value, including fwd_a/fwd_b.
- Normal load:
  - All fields load from ex_* inputs.
  - When ex_valid=0, the control groups are forced to 0 (bubble); the data fields still load.
  - mem_pcsrc <= ex_valid & ex_m_ctl[2] & ex_zero.
- Forward flags (computed from the incoming instruction, registered in the same edge):
  - fwd_a <= ex_valid & ex_wb_ctl[1] & (ex_wreg != 0) & (ex_wreg == id_rs).
  - fwd_b is the same expression with id_rt.
  - Register $0 never forwards.
- Widths: no arithmetic in this block; all fields pass through at exact width with no extension.
- Two-state pipeline-slot state machine:
  - EMPTY (mem_valid=0) and FULL (mem_valid=1).
  - EMPTY->FULL on load with ex_valid=1.
  - FULL->EMPTY on flush, or on load with ex_valid=0.
  - Stall holds the current state.
- X on stall/flush is not permitted. Behaviour is undefined and the bench flags it.

Decomposition:
- Shared package pipe_pkg:
  - constants REG_AW=5 and DATA_W=32
  - WB bit indices REGWRITE=1, MEMTOREG=0
  - M bit indices BRANCH=2, MEMREAD=1, MEMWRITE=0
  - enum slot_t {EMPTY, FULL}
- One natural sub-module: fwd_match, a combinational compare of ex_wreg against id_rs/id_rt with the regwrite/$0/valid qualification, reused later by the MEM/WB latch.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle with FULL contents -> all outputs 0 immediately, without waiting for a clk edge.
- Load: ex_valid=1, wb=2'b10, m=3'b000, alu_res=32'h0000_00AA, ex_wreg=5'b01010 -> next edge mem_wreg=01010, mem_alu_res=AA, mem_valid=1.
- Stall: stall=1 for 3 cycles while ex_wreg changes to 5'b10101 -> mem_wreg stays 01010 for all 3 cycles.
- Flush: flush=1 together with stall=1 -> mem_valid=0, mem_wb_ctl=0, mem_m_ctl=0, mem_pcsrc=0.
- Branch: m=3'b100, ex_zero=1, ex_valid=1 -> mem_pcsrc=1. Repeat with ex_zero=0 -> mem_pcsrc=0.
- Forwarding: regwrite=1, ex_wreg=5'b11111, id_rs=5'b11111, id_rt=5'b00101 -> fwd_a=1, fwd_b=0. Then ex_wreg=0 with id_rs=0 -> fwd_a=0.
